// File: rtl/alu_seq_pkg.sv
// -----------------------------------------------------------------------------
// alu_seq_pkg
//   Shared definitions for the wide sequential ALU initiator: request opcodes,
//   the opcode values understood by the external 4-bit ALU slice, the initiator
//   state encoding and the slice width.
//   No ports (package).
// -----------------------------------------------------------------------------
package alu_seq_pkg;

  // Width of one pass through the external ALU.
  localparam int SLICE_W = 4;

  // Request opcodes as presented on req_op.
  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_NOT = 3'b010,
    OP_AND = 3'b011,
    OP_OR  = 3'b100,
    OP_XOR = 3'b101,
    OP_LTU = 3'b110,
    OP_EQ  = 3'b111
  } op_e;

  // Opcodes understood by the external 4-bit ALU slice.
  localparam logic [2:0] ALU_SEL_ADD = 3'b000;
  localparam logic [2:0] ALU_SEL_NOT = 3'b010;
  localparam logic [2:0] ALU_SEL_AND = 3'b011;
  localparam logic [2:0] ALU_SEL_OR  = 3'b100;
  localparam logic [2:0] ALU_SEL_XOR = 3'b101;

  // Initiator sequencing states.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_e;

  // Subtract and unsigned compare both run as A + ~B + 1 on the adder.
  function automatic logic opInvertsB(input op_e op);
    return (op == OP_SUB) || (op == OP_LTU);
  endfunction

  // Ops whose slices are chained through the carry register.
  function automatic logic opChainsCarry(input op_e op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_LTU);
  endfunction

endpackage

// File: rtl/alu_wide_acc.sv
// -----------------------------------------------------------------------------
// alu_wide_acc
//   Slice-indexed result accumulator for the wide sequential ALU. Holds the
//   partial wide result and the carry between slices, and offers the result as
//   it will look once the current slice is merged, plus a zero reduce of it.
// Ports
//   clk            in   clock, rising edge
//   rst            in   asynchronous active-high reset
//   i_clr          in   clear result and carry (new request accepted)
//   i_wr           in   merge i_slice at i_idx and capture i_cf
//   i_idx          in   slice index being processed
//   i_slice        in   4-bit slice result from the external ALU
//   i_cf           in   slice carry-out from the external ALU
//   o_carry        out  registered carry from the previous slice
//   o_resultNext   out  stored result with the current slice merged in
//   o_nextZero     out  o_resultNext == 0
// -----------------------------------------------------------------------------
module alu_wide_acc
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int NSL   = WIDTH / SLICE_W,
  parameter int IDXW  = $clog2(NSL)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_clr,
  input  logic                i_wr,
  input  logic [IDXW-1:0]     i_idx,
  input  logic [SLICE_W-1:0]  i_slice,
  input  logic                i_cf,
  output logic                o_carry,
  output logic [WIDTH-1:0]    o_resultNext,
  output logic                o_nextZero
);

  logic [WIDTH-1:0] r_result;
  logic             r_carry;

  // The merged view lets the owner register the final wide result in the
  // same cycle the last slice comes back, without waiting a cycle.
  always_comb begin
    o_resultNext = r_result;
    o_resultNext[i_idx*SLICE_W +: SLICE_W] = i_slice;
  end

  assign o_nextZero = (o_resultNext == '0);
  assign o_carry    = r_carry;

  // Result and carry are cleared on accept so stale bits from the previous
  // op can never leak into the zero reduce used for eq.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_result <= '0;
      r_carry  <= 1'b0;
    end else if (i_clr) begin
      r_result <= '0;
      r_carry  <= 1'b0;
    end else if (i_wr) begin
      r_result <= o_resultNext;
      r_carry  <= i_cf;
    end
  end

endmodule

// File: rtl/alu_wide_seq.sv
// -----------------------------------------------------------------------------
// alu_wide_seq
//   Initiator that runs a WIDTH-bit operation through one external 4-bit ALU
//   slice, LSB nibble first, chaining carry, and returns the assembled result
//   and flags on a valid/ready response.
// Ports
//   clk, rst                    clock, asynchronous active-high reset
//   req_valid/req_ready         request handshake
//   req_op, req_a, req_b        opcode and WIDTH-bit operands
//   alu_a, alu_b, alu_sel,
//   alu_cin                     drive to the external 4-bit ALU
//   alu_out, alu_cf, alu_of     combinational result from the external ALU
//   rsp_valid/rsp_ready         response handshake
//   rsp_data, rsp_cf, rsp_of,
//   rsp_zf                      wide result and flags
//   of_sticky, sticky_clr       only with ALU_WIDE_SEQ_STICKY_EN defined:
//                               overflow seen on a delivered response / clear
// Configuration macro: ALU_WIDE_SEQ_STICKY_EN
// -----------------------------------------------------------------------------
module alu_wide_seq
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [2:0]         req_op,
  input  logic [WIDTH-1:0]   req_a,
  input  logic [WIDTH-1:0]   req_b,
  output logic [3:0]         alu_a,
  output logic [3:0]         alu_b,
  output logic [2:0]         alu_sel,
  output logic               alu_cin,
  input  logic [3:0]         alu_out,
  input  logic               alu_cf,
  input  logic               alu_of,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [WIDTH-1:0]   rsp_data,
  output logic               rsp_cf,
  output logic               rsp_of,
  output logic               rsp_zf
`ifdef ALU_WIDE_SEQ_STICKY_EN
  ,
  output logic               of_sticky,
  input  logic               sticky_clr
`endif
);

  localparam int NSL  = WIDTH / SLICE_W;
  localparam int IDXW = $clog2(NSL);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NSL - 1);

  state_e             r_state;
  state_e             w_nextState;
  logic [IDXW-1:0]    r_idx;
  op_e                r_op;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;

  logic               r_rspValid;
  logic [WIDTH-1:0]   r_rspData;
  logic               r_rspCf;
  logic               r_rspOf;
  logic               r_rspZf;

  logic               w_accept;
  logic               w_lastSlice;
  logic [SLICE_W-1:0] w_aSlice;
  logic [SLICE_W-1:0] w_bSlice;
  logic               w_carry;
  logic [WIDTH-1:0]   w_resultNext;
  logic               w_nextZero;
  logic [WIDTH-1:0]   w_rspData;
  logic               w_rspCf;
  logic               w_rspOf;

  assign w_accept    = (r_state == IDLE) && req_valid;
  assign w_lastSlice = (r_state == RUN) && (r_idx == LAST_IDX);
  assign w_aSlice    = r_a[r_idx*SLICE_W +: SLICE_W];
  assign w_bSlice    = r_b[r_idx*SLICE_W +: SLICE_W];

  alu_wide_acc #(
    .WIDTH (WIDTH)
  ) u_acc (
    .clk          (clk),
    .rst          (rst),
    .i_clr        (w_accept),
    .i_wr         (r_state == RUN),
    .i_idx        (r_idx),
    .i_slice      (alu_out),
    .i_cf         (alu_cf),
    .o_carry      (w_carry),
    .o_resultNext (w_resultNext),
    .o_nextZero   (w_nextZero)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_nextState;
  end

  // Next-state: one RUN cycle per slice, then hold in DONE until the
  // response is taken.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (req_valid)   w_nextState = RUN;
      RUN:     if (w_lastSlice) w_nextState = DONE;
      DONE:    if (rsp_ready)   w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // Outputs: the ALU is only driven while slices are running so that it
  // sees all-zero inputs when idle. Carry-in of slice 0 is the +1 of the
  // two's complement for sub/ltu; eq runs as xor and is reduced afterwards.
  always_comb begin
    req_ready = (r_state == IDLE);
    alu_a     = '0;
    alu_b     = '0;
    alu_sel   = ALU_SEL_ADD;
    alu_cin   = 1'b0;
    if (r_state == RUN) begin
      alu_a = w_aSlice;
      alu_b = opInvertsB(r_op) ? ~w_bSlice : w_bSlice;
      if (r_idx == '0) alu_cin = opInvertsB(r_op);
      else             alu_cin = opChainsCarry(r_op) ? w_carry : 1'b0;
      case (r_op)
        OP_NOT: begin
          alu_sel = ALU_SEL_NOT;
          alu_b   = '0;
        end
        OP_AND:  alu_sel = ALU_SEL_AND;
        OP_OR:   alu_sel = ALU_SEL_OR;
        OP_XOR:  alu_sel = ALU_SEL_XOR;
        OP_EQ:   alu_sel = ALU_SEL_XOR;
        default: alu_sel = ALU_SEL_ADD;
      endcase
    end
  end

  // Final response value, formed from the last slice as it comes back.
  // ltu's answer is the borrow of A - B, i.e. the inverted final carry.
  always_comb begin
    w_rspData = w_resultNext;
    w_rspCf   = 1'b0;
    w_rspOf   = 1'b0;
    case (r_op)
      OP_LTU: begin
        w_rspData    = '0;
        w_rspData[0] = ~alu_cf;
      end
      OP_EQ: begin
        w_rspData    = '0;
        w_rspData[0] = w_nextZero;
      end
      OP_ADD, OP_SUB: begin
        w_rspCf = alu_cf;
        w_rspOf = alu_of;
      end
      default: ;
    endcase
  end

  // Operand latch, slice index and response registers. The response is
  // held untouched in DONE so it stays stable under backpressure.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx      <= '0;
      r_op       <= OP_ADD;
      r_a        <= '0;
      r_b        <= '0;
      r_rspValid <= 1'b0;
      r_rspData  <= '0;
      r_rspCf    <= 1'b0;
      r_rspOf    <= 1'b0;
      r_rspZf    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (req_valid) begin
            r_op  <= op_e'(req_op);
            r_a   <= req_a;
            r_b   <= req_b;
            r_idx <= '0;
          end
        end
        RUN: begin
          if (r_idx == LAST_IDX) begin
            r_idx      <= '0;
            r_rspValid <= 1'b1;
            r_rspData  <= w_rspData;
            r_rspCf    <= w_rspCf;
            r_rspOf    <= w_rspOf;
            r_rspZf    <= (w_rspData == '0);
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        DONE: begin
          if (rsp_ready) r_rspValid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign rsp_valid = r_rspValid;
  assign rsp_data  = r_rspData;
  assign rsp_cf    = r_rspCf;
  assign rsp_of    = r_rspOf;
  assign rsp_zf    = r_rspZf;

`ifdef ALU_WIDE_SEQ_STICKY_EN
  logic r_ofSticky;

  // Remembers that any delivered response overflowed; a new overflow wins
  // over a clear arriving in the same cycle so it is never lost.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                 r_ofSticky <= 1'b0;
    else if (r_rspValid && rsp_ready && r_rspOf) r_ofSticky <= 1'b1;
    else if (sticky_clr)                     r_ofSticky <= 1'b0;
  end

  assign of_sticky = r_ofSticky;
`endif

endmodule

// File: tb/tb_alu_wide_seq.sv
// -----------------------------------------------------------------------------
// tb_alu_wide_seq
//   Self-checking bench for alu_wide_seq at WIDTH=16 with a behavioural 4-bit
//   ALU slice attached. Expected responses come from a full-width reference
//   model, queued on accept and popped when the response arrives.
//   Define ALU_WIDE_SEQ_STICKY_EN for both bench and RTL to cover the sticky
//   overflow flag.
// -----------------------------------------------------------------------------
module tb_alu_wide_seq;

  localparam int WIDTH = 16;
  localparam int NSL   = WIDTH / 4;

  typedef struct packed {
    logic [15:0] data;
    logic        cf;
    logic        of;
    logic        zf;
  } rsp_t;

  typedef struct packed {
    logic [2:0]  op;
    logic [15:0] a;
    logic [15:0] b;
  } stim_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic [15:0] req_a;
  logic [15:0] req_b;
  logic [3:0]  alu_a;
  logic [3:0]  alu_b;
  logic [2:0]  alu_sel;
  logic        alu_cin;
  logic [3:0]  alu_out;
  logic        alu_cf;
  logic        alu_of;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_data;
  logic        rsp_cf;
  logic        rsp_of;
  logic        rsp_zf;
`ifdef ALU_WIDE_SEQ_STICKY_EN
  logic        of_sticky;
  logic        sticky_clr;
`endif

  int   nCompared   = 0;
  int   nMismatched = 0;
  rsp_t expQ[$];
  logic [4:0] aluSum;

  always #5 clk = ~clk;

  alu_wide_seq #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_a     (req_a),
    .req_b     (req_b),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_sel   (alu_sel),
    .alu_cin   (alu_cin),
    .alu_out   (alu_out),
    .alu_cf    (alu_cf),
    .alu_of    (alu_of),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_cf    (rsp_cf),
    .rsp_of    (rsp_of),
    .rsp_zf    (rsp_zf)
`ifdef ALU_WIDE_SEQ_STICKY_EN
    ,
    .of_sticky (of_sticky),
    .sticky_clr(sticky_clr)
`endif
  );

  // Behavioural model of the external 4-bit ALU slice.
  always_comb begin
    aluSum  = '0;
    alu_out = '0;
    alu_cf  = 1'b0;
    alu_of  = 1'b0;
    case (alu_sel)
      3'b000: begin
        aluSum  = {1'b0, alu_a} + {1'b0, alu_b} + {4'b0, alu_cin};
        alu_out = aluSum[3:0];
        alu_cf  = aluSum[4];
        alu_of  = (alu_a[3] == alu_b[3]) && (aluSum[3] != alu_a[3]);
      end
      3'b010:  alu_out = ~alu_a;
      3'b011:  alu_out = alu_a & alu_b;
      3'b100:  alu_out = alu_a | alu_b;
      3'b101:  alu_out = alu_a ^ alu_b;
      default: alu_out = '0;
    endcase
  end

  // Full-width reference for the expected response.
  function automatic rsp_t refModel(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    rsp_t r;
    logic [16:0] s;
    r = '0;
    s = '0;
    case (op)
      3'd0: begin
        s      = {1'b0, a} + {1'b0, b};
        r.data = s[15:0];
        r.cf   = s[16];
        r.of   = (a[15] == b[15]) && (r.data[15] != a[15]);
      end
      3'd1: begin
        r.data = a - b;
        r.cf   = (a >= b);
        r.of   = (a[15] != b[15]) && (r.data[15] != a[15]);
      end
      3'd2: r.data = ~a;
      3'd3: r.data = a & b;
      3'd4: r.data = a | b;
      3'd5: r.data = a ^ b;
      3'd6: r.data = (a < b) ? 16'd1 : 16'd0;
      default: r.data = (a == b) ? 16'd1 : 16'd0;
    endcase
    r.zf = (r.data == 16'd0);
    return r;
  endfunction

  // Present a request (entered at a negedge) and hold it until accepted.
  // Returns at the negedge following the accepting edge.
  task automatic applyStimulus(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                               output bit accepted);
    req_op    = op;
    req_a     = a;
    req_b     = b;
    req_valid = 1'b1;
    accepted  = 1'b0;
    for (int i = 0; i < 40 && !accepted; i++) begin
      if (req_ready) begin
        accepted = 1'b1;
        expQ.push_back(refModel(op, a, b));
      end
      @(negedge clk);
    end
    req_valid = 1'b0;
  endtask

  // Wait for a response with rsp_ready high. lat counts edges from the
  // accepting edge (inclusive) through the edge that raised rsp_valid.
  task automatic collectResponse(output rsp_t obs, output int lat, output bit got);
    lat       = 1;
    got       = 1'b0;
    obs       = '0;
    rsp_ready = 1'b1;
    while (!rsp_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    if (rsp_valid) begin
      got = 1'b1;
      obs = '{rsp_data, rsp_cf, rsp_of, rsp_zf};
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    req_valid = 1'b0;
    req_op    = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b0;
`ifdef ALU_WIDE_SEQ_STICKY_EN
    sticky_clr = 1'b0;
`endif
    repeat (2) @(negedge clk);
    nCompared++;
    if ({req_ready, rsp_valid} !== 2'b10) begin
      nMismatched++;
      $display("[TB] FAIL reset_handshake: got ready/valid=%b expected 10", {req_ready, rsp_valid});
    end
    nCompared++;
    if ({rsp_data, rsp_cf, rsp_of, rsp_zf} !== 19'd0) begin
      nMismatched++;
      $display("[TB] FAIL reset_rsp: got %h expected 0", {rsp_data, rsp_cf, rsp_of, rsp_zf});
    end
    nCompared++;
    if ({alu_a, alu_b, alu_sel, alu_cin} !== 12'd0) begin
      nMismatched++;
      $display("[TB] FAIL reset_alu_drive: got %h expected 0", {alu_a, alu_b, alu_sel, alu_cin});
    end
`ifdef ALU_WIDE_SEQ_STICKY_EN
    nCompared++;
    if (of_sticky !== 1'b0) begin
      nMismatched++;
      $display("[TB] FAIL reset_sticky: got %b expected 0", of_sticky);
    end
`endif
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_ops();
    stim_t tbl[12] = '{
      '{3'd0, 16'h00FF, 16'h0001}, '{3'd0, 16'h7FFF, 16'h0001},
      '{3'd1, 16'h0000, 16'h0001}, '{3'd6, 16'h1234, 16'h1235},
      '{3'd7, 16'hABCD, 16'hABCD}, '{3'd5, 16'hABCD, 16'hABCD},
      '{3'd2, 16'h0F0F, 16'hFFFF}, '{3'd3, 16'hF0F3, 16'h3C3C},
      '{3'd4, 16'h1200, 16'h0034}, '{3'd1, 16'h8000, 16'h0001},
      '{3'd6, 16'h1235, 16'h1234}, '{3'd7, 16'hABCD, 16'hABCC}
    };
    rsp_t obs, exp;
    int   lat;
    bit   got, acc;
    for (int i = 0; i < 18; i++) begin
      stim_t s;
      if (i < 12) s = tbl[i];
      else        s = '{3'($urandom_range(7)), 16'($urandom), 16'($urandom)};
      applyStimulus(s.op, s.a, s.b, acc);
      collectResponse(obs, lat, got);
      nCompared++;
      if (!(acc && got) || expQ.size() == 0) begin
        nMismatched++;
        $display("[TB] FAIL op%0d_handshake: accepted=%b responded=%b expected 1/1", i, acc, got);
        continue;
      end
      exp = expQ.pop_front();
      nCompared++;
      if (obs.data !== exp.data) begin
        nMismatched++;
        $display("[TB] FAIL op%0d_data: op=%0d a=%h b=%h got %h expected %h", i, s.op, s.a, s.b, obs.data, exp.data);
      end
      nCompared++;
      if ({obs.cf, obs.of, obs.zf} !== {exp.cf, exp.of, exp.zf}) begin
        nMismatched++;
        $display("[TB] FAIL op%0d_flags: op=%0d got cf/of/zf=%b expected %b", i, s.op,
                 {obs.cf, obs.of, obs.zf}, {exp.cf, exp.of, exp.zf});
      end
      nCompared++;
      if (lat !== NSL + 1) begin
        nMismatched++;
        $display("[TB] FAIL op%0d_latency: got %0d expected %0d", i, lat, NSL + 1);
      end
    end
  endtask

  task automatic test_backpressure();
    rsp_t obs, exp;
    bit   acc;
    int   n;
    rsp_ready = 1'b0;
    applyStimulus(3'd1, 16'h9000, 16'h1234, acc);
    n = 0;
    while (!rsp_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    obs = '{rsp_data, rsp_cf, rsp_of, rsp_zf};
    exp = (expQ.size() != 0) ? expQ.pop_front() : ~refModel(3'd1, 16'h9000, 16'h1234);
    nCompared++;
    if (!(acc && rsp_valid) || obs !== exp) begin
      nMismatched++;
      $display("[TB] FAIL bp_response: valid=%b got %h expected %h", rsp_valid, obs, exp);
    end
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      nCompared++;
      if ({rsp_valid, req_ready} !== 2'b10 || {rsp_data, rsp_cf, rsp_of, rsp_zf} !== exp) begin
        nMismatched++;
        $display("[TB] FAIL bp_hold%0d: valid/ready=%b data=%h expected 10 %h", c,
                 {rsp_valid, req_ready}, {rsp_data, rsp_cf, rsp_of, rsp_zf}, exp);
      end
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    nCompared++;
    if ({rsp_valid, req_ready} !== 2'b01) begin
      nMismatched++;
      $display("[TB] FAIL bp_release: valid/ready=%b expected 01", {rsp_valid, req_ready});
    end
  endtask

  task automatic test_back_to_back();
    rsp_t obs1, obs2, exp;
    bit   acc, got1, got2;
    int   k, lat;
    rsp_ready = 1'b1;
    got1 = 1'b0;
    obs1 = '0;
    applyStimulus(3'd0, 16'h1111, 16'h2222, acc);
    req_op    = 3'd5;
    req_a     = 16'hFF00;
    req_b     = 16'h0FF0;
    req_valid = 1'b1;
    k = 0;
    while (!req_ready && k < 40) begin
      if (rsp_valid) begin
        got1 = 1'b1;
        obs1 = '{rsp_data, rsp_cf, rsp_of, rsp_zf};
      end
      @(negedge clk);
      k++;
    end
    expQ.push_back(refModel(3'd5, 16'hFF00, 16'h0FF0));
    @(negedge clk);
    req_valid = 1'b0;
    nCompared++;
    if (!acc || k + 1 !== NSL + 2) begin
      nMismatched++;
      $display("[TB] FAIL b2b_interval: got %0d expected %0d", k + 1, NSL + 2);
    end
    collectResponse(obs2, lat, got2);
    exp = (expQ.size() != 0) ? expQ.pop_front() : '0;
    nCompared++;
    if (!got1 || obs1 !== exp) begin
      nMismatched++;
      $display("[TB] FAIL b2b_first: got %h expected %h", obs1, exp);
    end
    exp = (expQ.size() != 0) ? expQ.pop_front() : '0;
    nCompared++;
    if (!got2 || obs2 !== exp) begin
      nMismatched++;
      $display("[TB] FAIL b2b_second: got %h expected %h", obs2, exp);
    end
  endtask

  task automatic test_reset_mid_run();
    rsp_t obs, exp;
    bit   acc, got;
    int   lat, badValid, badReady;
    rsp_ready = 1'b1;
    applyStimulus(3'd0, 16'h1234, 16'h4321, acc);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    if (expQ.size() != 0) void'(expQ.pop_front());
    @(negedge clk);
    rst = 1'b0;
    badValid = 0;
    badReady = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (rsp_valid !== 1'b0) badValid++;
      if (req_ready !== 1'b1) badReady++;
    end
    nCompared++;
    if (badValid !== 0) begin
      nMismatched++;
      $display("[TB] FAIL rst_mid_no_rsp: rsp_valid high in %0d cycles expected 0", badValid);
    end
    nCompared++;
    if (badReady !== 0) begin
      nMismatched++;
      $display("[TB] FAIL rst_mid_ready: req_ready low in %0d cycles expected 0", badReady);
    end
    applyStimulus(3'd1, 16'h5000, 16'h1000, acc);
    collectResponse(obs, lat, got);
    exp = (expQ.size() != 0) ? expQ.pop_front() : '0;
    nCompared++;
    if (!(acc && got) || obs !== exp) begin
      nMismatched++;
      $display("[TB] FAIL rst_mid_next_op: got %h expected %h", obs, exp);
    end
  endtask

`ifdef ALU_WIDE_SEQ_STICKY_EN
  task automatic test_sticky();
    stim_t seq4[4] = '{
      '{3'd0, 16'h7FFF, 16'h0001}, '{3'd0, 16'h0001, 16'h0001},
      '{3'd5, 16'h00FF, 16'h0F0F}, '{3'd1, 16'h0005, 16'h0003}
    };
    rsp_t obs, exp;
    bit   acc, got;
    int   lat;
    sticky_clr = 1'b0;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(seq4[i].op, seq4[i].a, seq4[i].b, acc);
      collectResponse(obs, lat, got);
      exp = (expQ.size() != 0) ? expQ.pop_front() : '0;
      nCompared++;
      if (!(acc && got) || obs.of !== exp.of || of_sticky !== 1'b1) begin
        nMismatched++;
        $display("[TB] FAIL sticky_hold%0d: rsp_of=%b sticky=%b expected of=%b sticky=1", i, obs.of, of_sticky, exp.of);
      end
    end
    sticky_clr = 1'b1;
    @(negedge clk);
    sticky_clr = 1'b0;
    nCompared++;
    if (of_sticky !== 1'b0) begin
      nMismatched++;
      $display("[TB] FAIL sticky_clear: got %b expected 0", of_sticky);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_ops();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_run();
`ifdef ALU_WIDE_SEQ_STICKY_EN
    test_sticky();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
